// File: rtl/operand_b_sel_pkg.sv
// ---------------------------------------------------------------------------
// operand_b_sel_pkg
// Shared encodings for the CPU datapath and control:
//   selb_e  - source select for operand B (MEMORY / SIGNAL / UNSIGNED / ACC)
//   state_e - state encoding of the operand-B fetch FSM
//   TMO_CNT_W - width of the memory-wait timeout counter (covers 1..255)
// ---------------------------------------------------------------------------
package operand_b_sel_pkg;

    typedef enum logic [1:0] {
        SELB_MEMORY   = 2'b00,
        SELB_SIGNAL   = 2'b01,
        SELB_UNSIGNED = 2'b10,
        SELB_ACC      = 2'b11
    } selb_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_WAIT_MEM = 2'b01,
        ST_DONE     = 2'b10
    } state_e;

    localparam int TMO_CNT_W = 8;

endpackage

// File: rtl/operand_b_sel_imm_extend.sv
// ---------------------------------------------------------------------------
// imm_extend
// Combinational widening of the instruction immediate to the datapath width.
// Ports:
//   imm_i  [IMM_LENGTH-1:0]  immediate field
//   sign_i                   1 = sign-extend, 0 = zero-extend
//   ext_o  [DATA_LENGTH-1:0] extended immediate
// IMM_LENGTH must be strictly less than DATA_LENGTH.
// ---------------------------------------------------------------------------
module imm_extend #(
    parameter int DATA_LENGTH = 16,
    parameter int IMM_LENGTH  = 11
) (
    input  logic [IMM_LENGTH-1:0]  imm_i,
    input  logic                   sign_i,
    output logic [DATA_LENGTH-1:0] ext_o
);

    localparam int EXT_W = DATA_LENGTH - IMM_LENGTH;

    logic fill_bit;

    // Upper bits copy the immediate MSB only in sign mode; otherwise zero.
    assign fill_bit = sign_i & imm_i[IMM_LENGTH-1];
    assign ext_o    = {{EXT_W{fill_bit}}, imm_i};

endmodule

// File: rtl/operand_b_sel.sv
// ---------------------------------------------------------------------------
// operand_b_sel
// Selects and registers operand B for the datapath. Immediate and accumulator
// sources complete one cycle after the request is accepted; the memory source
// waits in WAIT_MEM for mem_valid, giving up after MEM_TIMEOUT cycles with a
// zero operand and a sticky err flag.
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-high reset
//   req          operand request, accepted when req && ready
//   SelB[1:0]    source select (see operand_b_sel_pkg::selb_e)
//   from_memory  memory read data, qualified by mem_valid
//   mem_valid    from_memory valid this cycle
//   from_signal  instruction immediate field
//   from_acc     accumulator value
//   ready        high only in IDLE
//   mem_rd       memory read strobe, high throughout WAIT_MEM
//   outValue     registered selected operand
//   out_valid    one-cycle pulse marking a new outValue
//   err          sticky memory-timeout flag, cleared by the next accepted req
// ---------------------------------------------------------------------------
module operand_b_sel #(
    parameter int DATA_LENGTH = 16,
    parameter int IMM_LENGTH  = 11,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req,
    input  logic [1:0]             SelB,
    input  logic [DATA_LENGTH-1:0] from_memory,
    input  logic                   mem_valid,
    input  logic [IMM_LENGTH-1:0]  from_signal,
    input  logic [DATA_LENGTH-1:0] from_acc,
    output logic                   ready,
    output logic                   mem_rd,
    output logic [DATA_LENGTH-1:0] outValue,
    output logic                   out_valid,
    output logic                   err
);

    import operand_b_sel_pkg::*;

    state_e                 state_q;
    logic [TMO_CNT_W-1:0]   cnt_q;
    logic [TMO_CNT_W-1:0]   cnt_d;
    logic [DATA_LENGTH-1:0] outval_q;
    logic                   out_valid_q;
    logic                   err_q;

    selb_e                  sel_in;
    logic                   sign_mode;
    logic [DATA_LENGTH-1:0] ext_imm;
    logic [DATA_LENGTH-1:0] direct_val;
    logic                   tmo_hit;

    assign sel_in    = selb_e'(SelB);
    assign sign_mode = (sel_in == SELB_SIGNAL);

    imm_extend #(
        .DATA_LENGTH (DATA_LENGTH),
        .IMM_LENGTH  (IMM_LENGTH)
    ) u_imm_extend (
        .imm_i  (from_signal),
        .sign_i (sign_mode),
        .ext_o  (ext_imm)
    );

    // Non-memory sources are sampled straight into outValue at the accepting
    // edge, which is what makes later input changes irrelevant to the request.
    assign direct_val = (sel_in == SELB_ACC) ? from_acc : ext_imm;

    // The counter value after this WAIT_MEM cycle; reaching MEM_TIMEOUT
    // means this is the last cycle allowed to wait.
    assign cnt_d   = cnt_q + 8'd1;
    assign tmo_hit = (cnt_d == TMO_CNT_W'(MEM_TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            outval_q    <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        err_q <= 1'b0;
                        cnt_q <= '0;
                        if (sel_in == SELB_MEMORY) begin
                            state_q <= ST_WAIT_MEM;
                        end else begin
                            outval_q    <= direct_val;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_WAIT_MEM: begin
                    // Data arriving on the timeout cycle wins over the timeout.
                    if (mem_valid) begin
                        outval_q    <= from_memory;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else if (tmo_hit) begin
                        cnt_q       <= cnt_d;
                        outval_q    <= '0;
                        err_q       <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Decoded directly from the state register so reset clears them at once.
    assign ready     = (state_q == ST_IDLE);
    assign mem_rd    = (state_q == ST_WAIT_MEM);
    assign outValue  = outval_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;

endmodule
